memory_stage: RTL and testbench

- Pipeline MEM stage of the RISC-V core; sits directly upstream of the writeback stage.
- Issues loads/stores to data memory over a req/ack handshake and formats load data (byte/half extraction, sign/zero extension).
- Stalls the pipeline while memory is outstanding.
- Holds the MEM/WB pipeline register that drives alu_result_WB, mem_data_WB, pcPlus4_WB and result_set_WB into writeback.

---
 rtl/memory_stage.sv | 186 ++++++++++++++++++
 tb/tb_memory_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V MEM stage: data memory access, load formatting, MEM/WB register
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction in MEM
  input  logic        valid_MEM,
  input  logic        reg_write_MEM,
  input  logic [1:0]  result_set_MEM,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] store_data_MEM,
  input  logic [31:0] pcPlus4_MEM,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  // pipeline control
  output logic        stall_MEM,
  // MEM/WB pipeline register
  output logic        valid_WB,
  output logic        reg_write_WB,
  output logic [4:0]  rd_WB,
  output logic [1:0]  result_set_WB,
  output logic [31:0] alu_result_WB,
  output logic [31:0] mem_data_WB,
  output logic [31:0] pcPlus4_WB,
  output logic        mem_fault_WB
);

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  // Access decode
  logic [1:0]  byte_off;
  logic        size_half;
  logic        size_word;
  logic        misaligned;
  logic        mem_op;
  logic        mem_op_aligned;
  logic        mem_op_misaligned;
  logic        timeout_now;
  logic        fault_now;
  logic        load_done;

  // Load formatting
  logic [31:0] load_lane;
  logic [31:0] load_data;

  assign byte_off          = alu_result_MEM[1:0];
  assign size_half         = (funct3_MEM[1:0] == 2'b01);
  assign size_word         = (funct3_MEM[1:0] == 2'b10);
  assign misaligned        = (size_half & byte_off[0]) | (size_word & (byte_off != 2'b00));
  assign mem_op            = valid_MEM & (mem_read_MEM | mem_write_MEM);
  assign mem_op_aligned    = mem_op & ~misaligned;
  assign mem_op_misaligned = mem_op & misaligned;

  // Timeout fires only when the last allowed wait cycle sees no ack; a late ack still wins.
  assign timeout_now = (state == WAIT) & (wait_cnt == CNT_MAX) & ~dmem_ack;
  assign fault_now   = mem_op_misaligned | timeout_now;
  assign load_done   = mem_op_aligned & mem_read_MEM & dmem_ack;

  // State register: async reset abandons any outstanding access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: enter WAIT on a missed zero-wait ack, leave on ack or timeout
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (mem_op_aligned && !dmem_ack) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = CNT_ONE;
        end
      end
      WAIT: begin
        // Upstream is frozen while waiting, so losing mem_op here is only a safety exit.
        if (!mem_op_aligned || dmem_ack || timeout_now) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic: request/stall gating and store lane steering
  always_comb begin
    dmem_req   = ~rst & mem_op_aligned & ~timeout_now;
    stall_MEM  = ~rst & mem_op_aligned & ~dmem_ack & ~timeout_now;
    dmem_we    = mem_write_MEM;
    dmem_addr  = {alu_result_MEM[31:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_MEM;
    if (mem_write_MEM) begin
      case (funct3_MEM[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << byte_off;
          dmem_wdata = {4{store_data_MEM[7:0]}};
        end
        2'b01: begin
          dmem_be    = byte_off[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{store_data_MEM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = store_data_MEM;
        end
      endcase
    end
  end

  // Load formatting: shift addressed lane down, then sign/zero extend by access size
  always_comb begin
    load_lane = dmem_rdata >> {byte_off, 3'b000};
    case (funct3_MEM)
      3'b000:  load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_data = {24'h000000, load_lane[7:0]};
      3'b101:  load_data = {16'h0000, load_lane[15:0]};
      default: load_data = load_lane;
    endcase
  end

  // MEM/WB register: bubble while stalled, otherwise capture the finished instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_WB      <= 1'b0;
      reg_write_WB  <= 1'b0;
      rd_WB         <= '0;
      result_set_WB <= '0;
      alu_result_WB <= '0;
      mem_data_WB   <= '0;
      pcPlus4_WB    <= '0;
      mem_fault_WB  <= 1'b0;
    end else if (stall_MEM) begin
      valid_WB     <= 1'b0;
      reg_write_WB <= 1'b0;
      mem_fault_WB <= 1'b0;
    end else begin
      valid_WB      <= valid_MEM;
      reg_write_WB  <= reg_write_MEM & ~fault_now;
      rd_WB         <= rd_MEM;
      result_set_WB <= result_set_MEM;
      alu_result_WB <= alu_result_MEM;
      mem_data_WB   <= load_done ? load_data : 32'h0;
      pcPlus4_WB    <= pcPlus4_MEM;
      mem_fault_WB  <= fault_now;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;

  localparam int TO = 16;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_MEM, reg_write_MEM, mem_read_MEM, mem_write_MEM;
  logic [1:0]  result_set_MEM;
  logic [2:0]  funct3_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] alu_result_MEM, store_data_MEM, pcPlus4_MEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_MEM;
  logic        valid_WB, reg_write_WB, mem_fault_WB;
  logic [4:0]  rd_WB;
  logic [1:0]  result_set_WB;
  logic [31:0] alu_result_WB, mem_data_WB, pcPlus4_WB;

  int checks = 0;
  int errors = 0;

  memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_MEM(valid_MEM), .reg_write_MEM(reg_write_MEM), .result_set_MEM(result_set_MEM),
    .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM), .funct3_MEM(funct3_MEM),
    .rd_MEM(rd_MEM), .alu_result_MEM(alu_result_MEM), .store_data_MEM(store_data_MEM),
    .pcPlus4_MEM(pcPlus4_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_MEM(stall_MEM),
    .valid_WB(valid_WB), .reg_write_WB(reg_write_WB), .rd_WB(rd_WB),
    .result_set_WB(result_set_WB), .alu_result_WB(alu_result_WB), .mem_data_WB(mem_data_WB),
    .pcPlus4_WB(pcPlus4_WB), .mem_fault_WB(mem_fault_WB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load result: take the addressed bytes, then extend per funct3.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> (8 * int'(off));
    case (f3)
      3'b000:  return (lane[7]  ? 32'hFFFFFF00 : 32'h0) | (lane & 32'hFF);
      3'b001:  return (lane[15] ? 32'hFFFF0000 : 32'h0) | (lane & 32'hFFFF);
      3'b100:  return lane & 32'hFF;
      3'b101:  return lane & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  // Drive one instruction starting just after a falling edge; lat = cycle index of ack
  // (lat > TO means the memory never answers). Returns just after a falling edge.
  task automatic run_op(input string tag, input logic v, input logic rw, input logic rd_en,
                        input logic wr, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [1:0] rs, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] pc, input logic [31:0] rword, input int lat);
    int size;
    int off;
    int exp_stall;
    int cyc;
    bit mem_op, mis, aligned, to, fault, fin;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_data;
    size    = 1 << int'(f3[1:0]);
    off     = int'(addr[1:0]);
    mem_op  = v && (rd_en || wr);
    mis     = (off % size) != 0;
    aligned = mem_op && !mis;
    to      = aligned && (lat > TO);
    fault   = (mem_op && mis) || to;
    exp_stall = !aligned ? 0 : (lat > TO ? TO : lat);
    exp_data  = (aligned && rd_en && !to) ? ref_load(f3, addr[1:0], rword) : 32'h0;
    for (int b = 0; b < 4; b++) begin
      exp_be[b]        = !wr || (b >= off && b < off + size);
      exp_wd[8*b +: 8] = sdata[8*(b % size) +: 8];
    end
    if (!wr) exp_be = 4'hF;

    valid_MEM = v; reg_write_MEM = rw; mem_read_MEM = rd_en; mem_write_MEM = wr;
    funct3_MEM = f3; rd_MEM = rd; result_set_MEM = rs; alu_result_MEM = addr;
    store_data_MEM = sdata; pcPlus4_MEM = pc;

    cyc = 0;
    fin = 0;
    while (!fin) begin
      dmem_ack   = aligned && (cyc == lat);
      dmem_rdata = (cyc == lat) ? rword : $urandom();
      #1;
      check({tag, "_req"}, 32'(dmem_req), 32'(aligned && !(to && cyc == TO)));
      check({tag, "_stall"}, 32'(stall_MEM), 32'(cyc < exp_stall));
      if (aligned && cyc == 0) begin
        check({tag, "_we"}, 32'(dmem_we), 32'(wr));
        check({tag, "_addr"}, dmem_addr, addr & ~32'h3);
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        if (wr) check({tag, "_wdata"}, dmem_wdata, exp_wd);
      end
      @(posedge clk);
      @(negedge clk);
      if (cyc < exp_stall) begin
        check({tag, "_bubble_valid"}, 32'(valid_WB), 32'h0);
        check({tag, "_bubble_fault"}, 32'(mem_fault_WB), 32'h0);
      end else begin
        fin = 1;
      end
      cyc++;
    end
    dmem_ack = 1'b0;

    check({tag, "_valid_WB"}, 32'(valid_WB), 32'(v));
    check({tag, "_reg_write_WB"}, 32'(reg_write_WB), 32'(rw && !fault));
    check({tag, "_rd_WB"}, 32'(rd_WB), 32'(rd));
    check({tag, "_result_set_WB"}, 32'(result_set_WB), 32'(rs));
    check({tag, "_alu_result_WB"}, alu_result_WB, addr);
    check({tag, "_pcPlus4_WB"}, pcPlus4_WB, pc);
    check({tag, "_mem_data_WB"}, mem_data_WB, exp_data);
    check({tag, "_mem_fault_WB"}, 32'(mem_fault_WB), 32'(fault));
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_valid_WB"}, 32'(valid_WB), 32'h0);
    check({tag, "_reg_write_WB"}, 32'(reg_write_WB), 32'h0);
    check({tag, "_rd_WB"}, 32'(rd_WB), 32'h0);
    check({tag, "_result_set_WB"}, 32'(result_set_WB), 32'h0);
    check({tag, "_alu_result_WB"}, alu_result_WB, 32'h0);
    check({tag, "_mem_data_WB"}, mem_data_WB, 32'h0);
    check({tag, "_pcPlus4_WB"}, pcPlus4_WB, 32'h0);
    check({tag, "_mem_fault_WB"}, 32'(mem_fault_WB), 32'h0);
  endtask

  initial begin
    logic [2:0] load_f3 [5];
    logic [2:0] f3;
    logic [31:0] addr;
    int kind, lat;
    load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
    load_f3[3] = 3'b100; load_f3[4] = 3'b101;

    // Reset with an aligned load presented: nothing may leave the block.
    rst = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    valid_MEM = 1'b1; reg_write_MEM = 1'b1; mem_read_MEM = 1'b1; mem_write_MEM = 1'b0;
    funct3_MEM = 3'b010; rd_MEM = 5'd3; result_set_MEM = 2'b01; alu_result_MEM = 32'h40;
    store_data_MEM = 32'h0; pcPlus4_MEM = 32'h4;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(stall_MEM), 32'h0);
    check_wb_zero("rst");
    valid_MEM = 1'b0;
    rst = 1'b0;

    // Directed cases
    run_op("alu", 1, 1, 0, 0, 3'b000, 5'd1, 2'b00, 32'h1234, 32'h0, 32'h8, 32'h0, 0);
    run_op("lb", 1, 1, 1, 0, 3'b000, 5'd2, 2'b01, 32'h103, 32'h0, 32'hC, 32'h80FF_FF7F, 0);
    check("lb_const", mem_data_WB, 32'hFFFF_FF80);
    run_op("lbu", 1, 1, 1, 0, 3'b100, 5'd2, 2'b01, 32'h103, 32'h0, 32'h10, 32'h80FF_FF7F, 0);
    check("lbu_const", mem_data_WB, 32'h0000_0080);
    run_op("sh", 1, 0, 0, 1, 3'b001, 5'd0, 2'b00, 32'h202, 32'h0000_ABCD, 32'h14, 32'h0, 0);
    run_op("lw_wait3", 1, 1, 1, 0, 3'b010, 5'd5, 2'b01, 32'h40, 32'h0, 32'h18, 32'hDEAD_BEEF, 3);
    run_op("lw_timeout", 1, 1, 1, 0, 3'b010, 5'd6, 2'b01, 32'h44, 32'h0, 32'h1C, 32'h1, NEVER);
    run_op("lw_after_to", 1, 1, 1, 0, 3'b010, 5'd7, 2'b01, 32'h48, 32'h0, 32'h20, 32'h1357_9BDF, 0);
    run_op("lw_ack_at_to", 1, 1, 1, 0, 3'b010, 5'd8, 2'b01, 32'h4C, 32'h0, 32'h24, 32'h2468_ACE0, TO);
    run_op("lh_mis", 1, 1, 1, 0, 3'b001, 5'd9, 2'b01, 32'h101, 32'h0, 32'h28, 32'h0, 0);
    run_op("sw_mis", 1, 0, 0, 1, 3'b010, 5'd0, 2'b00, 32'h302, 32'h55, 32'h2C, 32'h0, 0);
    run_op("bubble", 0, 1, 1, 0, 3'b010, 5'd10, 2'b01, 32'h50, 32'h0, 32'h30, 32'h0, 0);

    // Reset in the middle of a wait: request dropped at once, WB cleared.
    valid_MEM = 1'b1; reg_write_MEM = 1'b1; mem_read_MEM = 1'b1; mem_write_MEM = 1'b0;
    funct3_MEM = 3'b010; rd_MEM = 5'd11; alu_result_MEM = 32'h60; dmem_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("midwait_req_before", 32'(dmem_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("midwait_req", 32'(dmem_req), 32'h0);
    check("midwait_stall", 32'(stall_MEM), 32'h0);
    check_wb_zero("midwait");
    valid_MEM = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_lw", 1, 1, 1, 0, 3'b010, 5'd12, 2'b01, 32'h64, 32'h0, 32'h34, 32'hCAFE_F00D, 2);

    // Randomized instruction mix
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      addr = $urandom();
      case ($urandom_range(0, 7))
        0, 1:    lat = 0;
        2:       lat = 1;
        3:       lat = 2;
        4:       lat = $urandom_range(3, 6);
        5:       lat = TO - 1;
        6:       lat = TO;
        default: lat = NEVER;
      endcase
      if (kind == 1) begin
        f3 = load_f3[$urandom_range(0, 4)];
        if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
        run_op("rnd_load", 1, 1'($urandom()), 1, 0, f3, 5'($urandom()), 2'($urandom()),
               addr, $urandom(), $urandom(), $urandom(), lat);
      end else if (kind == 2) begin
        f3 = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
        run_op("rnd_store", 1, 1'($urandom()), 0, 1, f3, 5'($urandom()), 2'($urandom()),
               addr, $urandom(), $urandom(), $urandom(), lat);
      end else if (kind == 3) begin
        f3 = load_f3[$urandom_range(0, 4)];
        run_op("rnd_invalid", 0, 1'($urandom()), 1'($urandom()), 1'($urandom()), f3,
               5'($urandom()), 2'($urandom()), addr, $urandom(), $urandom(), $urandom(), lat);
      end else begin
        run_op("rnd_alu", 1, 1'($urandom()), 0, 0, 3'($urandom()), 5'($urandom()),
               2'($urandom()), addr, $urandom(), $urandom(), $urandom(), lat);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
